pdn_rail_sequencer: RTL and testbench
=====================================

PDN_RAIL_SEQUENCER -- requirements
Module: pdn_rail_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_RAILS, 6, number of sequenced supply rails (VDD1..VDD6 order).
- TIMEOUT_CYC, 1000, maximum wait for a rail's power-good after enable.
- SETTLE_CYC, 16, hold time after power-good before the next rail.
- OFF_DLY_CYC, 16, discharge wait after each rail disable.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- pwr_req, in, 1, level request: 1 = rails on, 0 = rails off.
- fault_clr, in, 1, one-cycle pulse that clears a latched fault.
- pgood, in, NUM_RAILS, asynchronous per-rail power-good.
- rail_en, out, NUM_RAILS, per-rail supply enable.
- all_good, out, 1, all rails on and settled.
- busy, out, 1, sequencing in progress.
- fault, out, 1, latched fault.
- fault_rail, out, 3, index of the failing rail.

Function
REQ-003 pgood SHALL pass through a 2-flop synchronizer per bit; all uses refer to the synchronized value (2-cycle latency).
REQ-004 The FSM SHALL have the states OFF, UP_WAIT, UP_SETTLE, ON, DOWN_DLY, FLT_DOWN and FAULT.
REQ-005 OFF with pwr_req=1 SHALL go to UP_WAIT with idx=0 and set rail_en[0] on the transition edge.
REQ-006 In UP_WAIT, pgood[idx]=1 SHALL go to UP_SETTLE with the counter cleared.
REQ-007 In UP_WAIT, if the counter reaches TIMEOUT_CYC before pgood[idx] rises, the block SHALL latch fault_rail=idx and go to FLT_DOWN.
REQ-008 UP_SETTLE SHALL wait SETTLE_CYC cycles, then:
- idx<NUM_RAILS-1: increment idx, set rail_en[idx], go to UP_WAIT.
- otherwise: go to ON.
REQ-009 ON SHALL assert all_good; the rail enables stay set.
REQ-010 In ON, pwr_req=0 SHALL clear rail_en[NUM_RAILS-1] and go to DOWN_DLY with idx=NUM_RAILS-1.
REQ-011 DOWN_DLY SHALL wait OFF_DLY_CYC cycles, then:
- idx>0: decrement idx, clear rail_en[idx], restart the wait.
- otherwise: go to OFF.
REQ-012 pwr_req=0 during UP_WAIT or UP_SETTLE SHALL clear rail_en[idx] and enter DOWN_DLY from the current idx (reverse from the highest enabled rail).
REQ-013 pwr_req=1 during DOWN_DLY SHALL be ignored until OFF is reached; OFF then restarts the sequence.
REQ-014 A loss of any enabled rail's pgood while in UP_SETTLE or ON SHALL latch fault_rail (lowest failing index) and go to FLT_DOWN.
REQ-015 FLT_DOWN SHALL perform the DOWN_DLY reverse sequence from the highest enabled rail, then enter FAULT.
REQ-016 fault SHALL be set on entry to FLT_DOWN and remain set through FAULT.
REQ-017 In FAULT, all rail_en SHALL be 0; fault_clr=1 SHALL clear fault and fault_rail and go to OFF.
REQ-018 fault_clr in any other state SHALL be ignored.
REQ-019 busy SHALL be 1 in UP_WAIT, UP_SETTLE, DOWN_DLY and FLT_DOWN, and 0 otherwise.
REQ-020 The cycle counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide, saturating, and cleared on every state change.
REQ-021 At most one rail_en bit SHALL change per cycle.

Reset
REQ-022 rst_n low SHALL asynchronously force the state to OFF, rail_en=0, all_good=0, busy=0, fault=0, fault_rail=0, idx=0, counter=0 and the synchronizers to 0.
REQ-023 Reset asserted mid-sequence SHALL drop all rails immediately; this is the only non-sequenced shutdown.

Structure
REQ-024 The state enum and default timing constants SHALL live in the shared package pdn_pkg.
REQ-025 The pgood synchronizer SHALL be the sub-module pdn_sync2, parameterized by width.

Verification
(Parameters: TIMEOUT_CYC=8, SETTLE_CYC=2, OFF_DLY_CYC=2, with pgood mirroring rail_en after 3 cycles.)
REQ-026 Power-up: pwr_req 0->1 -> rail_en steps 000001..111111 in order, all_good=1, fault=0.
REQ-027 Power-down: from ON, pwr_req=0 -> rails clear 5..0 at least 2 cycles apart, final state OFF, busy=0.
REQ-028 Timeout: pgood[3] held 0 -> after 8 cycles fault=1, fault_rail=3, rails 3..0 cleared in reverse order, then FAULT.
REQ-029 Runtime loss: in ON, drop pgood[1] -> fault_rail=1, reverse shutdown; fault_clr -> OFF with fault=0.
REQ-030 Abort: pwr_req=0 while waiting on rail 2 -> rails 2,1,0 cleared in order, no fault.
REQ-031 Async reset: rst_n low mid power-up -> rail_en=0 in the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/pdn_pkg.sv
// Shared definitions for the power-rail sequencer: FSM state encoding,
// default timing constants and a lowest-index priority helper.
package pdn_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_UP_WAIT   = 3'd1,
        ST_UP_SETTLE = 3'd2,
        ST_ON        = 3'd3,
        ST_DOWN_DLY  = 3'd4,
        ST_FLT_DOWN  = 3'd5,
        ST_FAULT     = 3'd6
    } pdn_state_e;

    localparam int DEF_NUM_RAILS   = 6;
    localparam int DEF_TIMEOUT_CYC = 1000;
    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_OFF_DLY_CYC = 16;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pdn_sync2.sv
// Two-flop synchronizer bank for asynchronous status inputs; every bit is
// synchronized independently and resets to 0.
module pdn_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdn_rail_sequencer.sv
// Power-rail sequencer: enables rails one at a time in ascending order,
// waiting for power-good and a settle period per rail, and shuts them down
// in reverse order with a discharge delay, on request or on a rail fault.
module pdn_rail_sequencer
    import pdn_pkg::*;
#(
    parameter int NUM_RAILS   = DEF_NUM_RAILS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int OFF_DLY_CYC = DEF_OFF_DLY_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwr_req,
    input  logic                 fault_clr,
    input  logic [NUM_RAILS-1:0] pgood,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 all_good,
    output logic                 busy,
    output logic                 fault,
    output logic [2:0]           fault_rail
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] TIMEOUT_VAL  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] OFF_DLY_LAST = CW'(OFF_DLY_CYC - 1);
    localparam logic [2:0]    TOP_IDX      = 3'(NUM_RAILS - 1);

    pdn_state_e           state, state_d;
    logic [2:0]           idx, idx_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [NUM_RAILS-1:0] rail_en_d;
    logic [NUM_RAILS-1:0] pg_s;
    logic [NUM_RAILS-1:0] lost;
    logic [7:0]           lost_w;
    logic                 fault_d;
    logic [2:0]           fault_rail_d;
    logic                 restart;

    pdn_sync2 #(.WIDTH(NUM_RAILS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pgood),
        .q     (pg_s)
    );

    // An enabled rail whose synchronized power-good is low.
    assign lost = rail_en & ~pg_s;

    always_comb begin
        lost_w                  = '0;
        lost_w[NUM_RAILS-1:0]   = lost;
    end

    assign all_good = (state == ST_ON);
    assign busy     = (state inside {ST_UP_WAIT, ST_UP_SETTLE, ST_DOWN_DLY, ST_FLT_DOWN});

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        rail_en_d    = rail_en;
        fault_d      = fault;
        fault_rail_d = fault_rail;
        restart      = 1'b0;

        case (state)
            ST_OFF: begin
                if (pwr_req) begin
                    state_d      = ST_UP_WAIT;
                    idx_d        = '0;
                    rail_en_d[0] = 1'b1;
                end
            end

            ST_UP_WAIT: begin
                if (!pg_s[idx] && cnt == TIMEOUT_VAL) begin
                    state_d        = ST_FLT_DOWN;
                    fault_d        = 1'b1;
                    fault_rail_d   = idx;
                    rail_en_d[idx] = 1'b0;
                end else if (!pwr_req) begin
                    state_d        = ST_DOWN_DLY;
                    rail_en_d[idx] = 1'b0;
                end else if (pg_s[idx]) begin
                    state_d = ST_UP_SETTLE;
                end
            end

            ST_UP_SETTLE: begin
                if (|lost) begin
                    state_d        = ST_FLT_DOWN;
                    fault_d        = 1'b1;
                    fault_rail_d   = lowest_set(lost_w);
                    rail_en_d[idx] = 1'b0;
                end else if (!pwr_req) begin
                    state_d        = ST_DOWN_DLY;
                    rail_en_d[idx] = 1'b0;
                end else if (cnt == SETTLE_LAST) begin
                    if (idx < TOP_IDX) begin
                        state_d                 = ST_UP_WAIT;
                        idx_d                   = idx + 3'd1;
                        rail_en_d[idx + 3'd1]   = 1'b1;
                    end else begin
                        state_d = ST_ON;
                    end
                end
            end

            ST_ON: begin
                if (|lost) begin
                    state_d            = ST_FLT_DOWN;
                    fault_d            = 1'b1;
                    fault_rail_d       = lowest_set(lost_w);
                    idx_d              = TOP_IDX;
                    rail_en_d[TOP_IDX] = 1'b0;
                end else if (!pwr_req) begin
                    state_d            = ST_DOWN_DLY;
                    idx_d              = TOP_IDX;
                    rail_en_d[TOP_IDX] = 1'b0;
                end
            end

            // Both shutdown flavours share the reverse walk; only the exit differs.
            ST_DOWN_DLY, ST_FLT_DOWN: begin
                if (cnt == OFF_DLY_LAST) begin
                    if (idx != 3'd0) begin
                        idx_d                 = idx - 3'd1;
                        rail_en_d[idx - 3'd1] = 1'b0;
                        restart               = 1'b1;
                    end else begin
                        state_d = (state == ST_DOWN_DLY) ? ST_OFF : ST_FAULT;
                    end
                end
            end

            ST_FAULT: begin
                rail_en_d = '0;
                if (fault_clr) begin
                    state_d      = ST_OFF;
                    fault_d      = 1'b0;
                    fault_rail_d = '0;
                end
            end

            default: begin
                state_d   = ST_OFF;
                rail_en_d = '0;
            end
        endcase

        cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        if (restart || state_d != state) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            idx        <= '0;
            cnt        <= '0;
            rail_en    <= '0;
            fault      <= 1'b0;
            fault_rail <= '0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            rail_en    <= rail_en_d;
            fault      <= fault_d;
            fault_rail <= fault_rail_d;
        end
    end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Bench for pdn_rail_sequencer: a rail plant echoes rail_en onto pgood after
// three cycles, and a rail-count model predicts every output each cycle.
module tb_pdn_rail_sequencer;

    localparam int NR = 6;
    localparam int TO = 8;
    localparam int ST = 2;
    localparam int OD = 2;
    localparam int W  = NR + 6;

    localparam int P_OFF    = 0;
    localparam int P_RAMP   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_ON     = 3;
    localparam int P_DRAIN  = 4;
    localparam int P_FDRAIN = 5;
    localparam int P_FAULTED = 6;

    logic          clk;
    logic          rst_n;
    logic          pwr_req;
    logic          fault_clr;
    logic [NR-1:0] pgood;
    logic [NR-1:0] rail_en;
    logic          all_good;
    logic          busy;
    logic          fault;
    logic [2:0]    fault_rail;

    pdn_rail_sequencer #(
        .NUM_RAILS   (NR),
        .TIMEOUT_CYC (TO),
        .SETTLE_CYC  (ST),
        .OFF_DLY_CYC (OD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwr_req    (pwr_req),
        .fault_clr  (fault_clr),
        .pgood      (pgood),
        .rail_en    (rail_en),
        .all_good   (all_good),
        .busy       (busy),
        .fault      (fault),
        .fault_rail (fault_rail)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp;
    int            n_err;
    logic [W-1:0]  exp_q[$];
    logic [NR-1:0] kill_mask;
    logic [NR-1:0] eh[3];

    // model: number of rails enabled (always a thermometer), phase, timer
    int            m_phase;
    int            m_n;
    int            m_t;
    logic          m_fault;
    int            m_frail;
    logic [NR-1:0] ph[3];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_OFF;
        m_n     = 0;
        m_t     = 0;
        m_fault = 1'b0;
        m_frail = 0;
        for (int i = 0; i < 3; i++) ph[i] = '0;
    endtask

    function automatic logic [W-1:0] model_out();
        logic [NR-1:0] en;
        logic          bsy;
        en  = NR'((1 << m_n) - 1);
        bsy = (m_phase == P_RAMP) || (m_phase == P_SETTLE) ||
              (m_phase == P_DRAIN) || (m_phase == P_FDRAIN);
        return {en, (m_phase == P_ON), bsy, m_fault, 3'(m_frail)};
    endfunction

    task automatic enter_fault(input int r);
        m_fault = 1'b1;
        m_frail = r;
        m_n     = m_n - 1;
        m_phase = P_FDRAIN;
        m_t     = 0;
    endtask

    task automatic model_step(input logic req, input logic clr, input logic [NR-1:0] sv);
        logic [NR-1:0] en;
        logic [NR-1:0] lost;
        int            low;
        en   = NR'((1 << m_n) - 1);
        lost = en & ~sv;
        low  = -1;
        for (int i = NR - 1; i >= 0; i--) if (lost[i]) low = i;
        case (m_phase)
            P_OFF: if (req) begin m_phase = P_RAMP; m_n = 1; m_t = 0; end
            P_RAMP: begin
                if (!sv[m_n-1] && m_t == TO) enter_fault(m_n - 1);
                else if (!req) begin m_n--; m_phase = P_DRAIN; m_t = 0; end
                else if (sv[m_n-1]) begin m_phase = P_SETTLE; m_t = 0; end
                else m_t++;
            end
            P_SETTLE: begin
                if (low >= 0) enter_fault(low);
                else if (!req) begin m_n--; m_phase = P_DRAIN; m_t = 0; end
                else if (m_t == ST - 1) begin
                    m_t = 0;
                    if (m_n < NR) begin m_n++; m_phase = P_RAMP; end
                    else m_phase = P_ON;
                end else m_t++;
            end
            P_ON: begin
                if (low >= 0) enter_fault(low);
                else if (!req) begin m_n--; m_phase = P_DRAIN; m_t = 0; end
            end
            P_DRAIN, P_FDRAIN: begin
                if (m_t == OD - 1) begin
                    m_t = 0;
                    if (m_n > 0) m_n--;
                    else m_phase = (m_phase == P_DRAIN) ? P_OFF : P_FAULTED;
                end else m_t++;
            end
            P_FAULTED: if (clr) begin m_phase = P_OFF; m_fault = 1'b0; m_frail = 0; end
            default: m_phase = P_OFF;
        endcase
    endtask

    // Plant, scoreboard compare and model advance, all away from the active edge.
    always @(negedge clk) begin : neg_proc
        logic [NR-1:0] p;
        logic [W-1:0]  act;
        p     = eh[2] & ~kill_mask;
        eh[2] = eh[1];
        eh[1] = eh[0];
        eh[0] = rail_en;
        pgood = p;
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(model_out());
        end else begin
            act = {rail_en, all_good, busy, fault, fault_rail};
            if (exp_q.size() > 0) check("outputs", act, exp_q.pop_front());
            ph[2] = ph[1];
            ph[1] = ph[0];
            ph[0] = p;
            model_step(pwr_req, fault_clr, ph[2]);
            exp_q.push_back(model_out());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
    endtask

    task automatic wait_all_good(input int budget);
        for (int i = 0; i < budget && !all_good; i++) step();
    endtask

    task automatic wait_fault(input int budget);
        for (int i = 0; i < budget && !fault; i++) step();
    endtask

    task automatic wait_quiet(input int budget);
        for (int i = 0; i < budget && (busy || rail_en != '0); i++) step();
    endtask

    task automatic wait_rails(input logic [NR-1:0] v, input int budget);
        for (int i = 0; i < budget && rail_en != v; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        pwr_req   = 1'b0;
        fault_clr = 1'b0;
        pgood     = '0;
        kill_mask = '0;
        for (int i = 0; i < 3; i++) eh[i] = '0;
        model_reset();

        idle(3);
        check("reset_rail_en", W'(rail_en), W'(0));
        check("reset_flags", W'({all_good, busy, fault}), W'(0));
        check("reset_fault_rail", W'(fault_rail), W'(0));
        rst_n = 1'b1;
        idle(8);

        // power-up
        pwr_req = 1'b1;
        wait_all_good(300);
        check("pwrup_all_good", W'(all_good), W'(1));
        check("pwrup_rails", W'(rail_en), W'(6'h3F));
        check("pwrup_no_fault", W'(fault), W'(0));
        idle(5);

        // power-down
        pwr_req = 1'b0;
        wait_quiet(100);
        check("pwrdn_rails", W'(rail_en), W'(0));
        check("pwrdn_busy", W'({busy, all_good}), W'(0));
        idle(10);

        // timeout on rail 3
        kill_mask = 6'b001000;
        pwr_req   = 1'b1;
        wait_fault(300);
        check("timeout_fault", W'(fault), W'(1));
        check("timeout_rail", W'(fault_rail), W'(3));
        check("timeout_rails_at_fault", W'(rail_en), W'(6'b000111));
        pwr_req = 1'b0;
        pulse_clr();
        wait_quiet(100);
        check("timeout_drained", W'(rail_en), W'(0));
        check("timeout_fault_held", W'(fault), W'(1));
        pulse_clr();
        check("timeout_cleared", W'({fault, fault_rail}), W'(0));
        kill_mask = '0;
        idle(10);

        // runtime loss of rail 1
        pwr_req = 1'b1;
        wait_all_good(300);
        kill_mask = 6'b000010;
        wait_fault(50);
        check("loss_fault_rail", W'({fault, fault_rail}), W'({1'b1, 3'd1}));
        pwr_req = 1'b0;
        wait_quiet(100);
        check("loss_drained", W'(rail_en), W'(0));
        pulse_clr();
        check("loss_cleared", W'({fault, busy}), W'(0));
        kill_mask = '0;
        idle(10);

        // abort while waiting on rail 2
        pwr_req = 1'b1;
        wait_rails(6'b000111, 200);
        pwr_req = 1'b0;
        wait_quiet(100);
        check("abort_rails", W'(rail_en), W'(0));
        check("abort_no_fault", W'(fault), W'(0));
        idle(10);

        // asynchronous reset mid power-up
        pwr_req = 1'b1;
        wait_rails(6'b000011, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_rail_en", W'(rail_en), W'(0));
        check("areset_flags", W'({all_good, busy, fault, fault_rail}), W'(0));
        pwr_req = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(12);

        // randomized requests, rail kills and clear pulses
        for (int it = 0; it < 30; it++) begin
            int hold;
            if ($urandom_range(0, 9) < 2) kill_mask = NR'(1) << $urandom_range(0, NR - 1);
            else kill_mask = '0;
            pwr_req = ($urandom_range(0, 3) != 0);
            hold    = $urandom_range(3, 90);
            for (int c = 0; c < hold; c++) begin
                fault_clr = ($urandom_range(0, 15) == 0);
                step();
            end
            fault_clr = 1'b0;
        end

        kill_mask = '0;
        pwr_req   = 1'b0;
        idle(100);
        pulse_clr();
        idle(4);
        check("final_quiet", W'({rail_en, busy, fault}), W'(0));
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
